env_vca: RTL and testbench
==========================

Name: env_vca

Overview:
- Envelope-controlled amplifier: the consumer end of the ADSR envelope interface.
- Takes the envelope level (dout) and voice-active flag (vout) from the ADSR generator and a signed oscillator sample stream; outputs the amplitude-scaled sample.
- Gain changes apply only at sample zero crossings, or after a hold timeout, to avoid clicks.
- Multiplication is a serial shift-add (one gain bit per clock) to save area; sits between oscillator and output mixer.

Parameters:
- nbit_data, 6: envelope level width (matches ADSR dout width).
- nbit_sample, 8: signed two's-complement sample width.
- nbit_hold, 6: width of the zero-crossing timeout counter; timeout = 2**nbit_hold accepted samples.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  nbit_data  envelope level from ADSR, unsigned.
- vin  in  1  envelope active (ADSR vout); 0 forces target gain 0.
- sample_in  in  nbit_sample  signed input sample.
- sample_valid  in  1  one-cycle strobe, sample_in valid.
- dout  out  nbit_sample  signed scaled sample, held until next result.
- dout_valid  out  1  one-cycle strobe, dout updated.
- busy  out  1  multiplier running; sample_valid ignored.
- ovr  out  1  one-cycle pulse: sample_valid arrived while busy (sample dropped).

Behaviour:
- Reset (rstn=0, async): dout=0, dout_valid=0, busy=0, ovr=0, gain register=0, previous-sign register=0 (positive), hold counter=0, FSM=IDLE, accumulator=0.
- Target gain = vin ? din : 0, sampled only at sample acceptance.
- FSM states: IDLE, MUL. IDLE --sample_valid--> MUL (accept). MUL --bit counter = nbit_data-1--> IDLE. MUL ignores sample_valid and pulses ovr for each such cycle.
- At acceptance edge: capture sample_in; evaluate update = (sign(sample_in) != previous sign) OR (sample_in == 0) OR (hold counter == 2**nbit_hold-1).
- If update: gain <= target gain, hold counter <= 0. Else: hold counter +1.
- Previous sign <= sign(sample_in). The updated gain applies to the same accepted sample.
- Multiply: accumulator width nbit_sample+nbit_data, signed. Cleared at acceptance. For MUL cycles i = 0..nbit_data-1: if gain[i], acc += sign-extended sample << i.
- Result = acc arithmetic-shifted right by nbit_data, i.e. acc[nbit_sample+nbit_data-1:nbit_data], floor rounding.
- Full-scale gain (2**nbit_data-1) yields sample*63/64. Result always fits nbit_sample; no saturation needed.
- Latency: dout/dout_valid update on the nbit_data-th edge after the acceptance edge.
- busy is high from the edge after acceptance until that edge. A sample may be accepted in the dout_valid cycle (back-to-back throughput = 1 sample per nbit_data+1 clocks).
- vin changes mid-multiply do not affect the running product.
- Reset mid-MUL aborts: no dout_valid is emitted.
- Hold counter saturates logic: compare at terminal value, reset on update. Wrap is impossible.

Decomposition:
- Shared package/include: cnbit_data, cnbit_sample defaults, FSM state encodings (IDLE=1'b0, MUL=1'b1).
- One sub-module, vca_serial_mul:
  - Inputs: start, sample, gain.
  - Outputs: product, done.
  - Owns the accumulator and bit counter.
- env_vca keeps the zero-crossing, hold and gain logic.

Test Plan:
- Reset, then vin=1, din=63, alternating samples 100, -100 (each is a zero crossing) → dout 0 for the first (gain starts 0, no crossing from positive reset sign), then -99, 98, -99. dout_valid arrives exactly 6 edges after each accept.
- Gain at 63, din changes to 32, samples 10, 20, 30, then -5 → outputs 9, 19, 29 (gain held), then -3 (gain 32 applied at the crossing).
- Gain 0, vin=1, din=32, 64 consecutive samples of +50 → first 63 outputs 0, 64th output 25 (timeout update).
- Gain 63, vin falls to 0, then samples 40, -40 → 39, then 0 (target 0 latched at the crossing).
- sample_valid asserted on 3 consecutive clocks → first accepted; ovr pulses twice and busy is high during those cycles; only one dout_valid.
- Assert rstn=0 during MUL cycle 3 → all outputs 0 immediately, no dout_valid; the next sample after release uses gain 0.

Source files
------------

// File: rtl/env_vca_pkg.sv
// Shared defaults and FSM encoding for the envelope-controlled amplifier.
package env_vca_pkg;

  localparam int cnbit_data   = 6;
  localparam int cnbit_sample = 8;
  localparam int cnbit_hold   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } vca_state_t;

endpackage

// File: rtl/vca_serial_mul.sv
// Serial shift-add multiplier: signed sample times unsigned gain, one gain bit per clock.
module vca_serial_mul
  import env_vca_pkg::*;
#(
  parameter int nbit_data   = cnbit_data,
  parameter int nbit_sample = cnbit_sample
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic signed [nbit_sample-1:0] sample,
  input  logic        [nbit_data-1:0]   gain,
  output logic signed [nbit_sample-1:0] product,
  output logic                          done
);

  localparam int acc_w = nbit_sample + nbit_data;
  localparam int cnt_w = (nbit_data > 1) ? $clog2(nbit_data) : 1;

  logic signed [acc_w-1:0]       acc_p0;
  logic signed [acc_w-1:0]       acc_nxt;
  logic signed [acc_w-1:0]       sample_ext;
  logic signed [acc_w-1:0]       addend;
  logic signed [nbit_sample-1:0] sample_p0;
  logic        [nbit_data-1:0]   gain_p0;
  logic        [cnt_w-1:0]       bit_cnt;
  logic                          run;

  // Drop the fractional gain bits; arithmetic slice gives floor rounding.
  function automatic logic signed [nbit_sample-1:0] floor_scale(input logic signed [acc_w-1:0] a);
    return a[acc_w-1:nbit_data];
  endfunction

  always_comb begin
    sample_ext = {{nbit_data{sample_p0[nbit_sample-1]}}, sample_p0};
    addend     = sample_ext << bit_cnt;
    acc_nxt    = gain_p0[bit_cnt] ? (acc_p0 + addend) : acc_p0;
    done       = run && (bit_cnt == cnt_w'(nbit_data - 1));
    product    = floor_scale(acc_nxt);
  end

  // Operand capture at start, then one partial product per clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_p0    <= '0;
      sample_p0 <= '0;
      gain_p0   <= '0;
      bit_cnt   <= '0;
      run       <= 1'b0;
    end else if (start) begin
      acc_p0    <= '0;
      sample_p0 <= sample;
      gain_p0   <= gain;
      bit_cnt   <= '0;
      run       <= 1'b1;
    end else if (run) begin
      acc_p0  <= acc_nxt;
      bit_cnt <= bit_cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/env_vca.sv
// Envelope VCA: gain follows the ADSR level but only changes at zero crossings or hold timeout.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int nbit_data   = cnbit_data,
  parameter int nbit_sample = cnbit_sample,
  parameter int nbit_hold   = cnbit_hold
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic        [nbit_data-1:0]   din,
  input  logic                          vin,
  input  logic signed [nbit_sample-1:0] sample_in,
  input  logic                          sample_valid,
  output logic signed [nbit_sample-1:0] dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          ovr
);

  vca_state_t state, state_nxt;

  logic [nbit_data-1:0]          gain;
  logic [nbit_data-1:0]          gain_nxt;
  logic [nbit_data-1:0]          target;
  logic [nbit_hold-1:0]          hold_cnt;
  logic                          prev_sign;
  logic                          sample_sign;
  logic                          accept;
  logic                          update;
  logic                          mul_done;
  logic signed [nbit_sample-1:0] mul_product;

  always_comb begin
    accept      = (state == IDLE) && sample_valid;
    sample_sign = sample_in[nbit_sample-1];
    target      = vin ? din : '0;
    update      = (sample_sign != prev_sign) || (sample_in == '0) || (hold_cnt == '1);
    // The freshly chosen gain is used for the very sample that triggered it
    gain_nxt    = update ? target : gain;
    busy        = (state == MUL);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid) state_nxt = MUL;
      MUL:     if (mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Acceptance stage: zero-crossing detect, hold timer and gain register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gain      <= '0;
      hold_cnt  <= '0;
      prev_sign <= 1'b0;
    end else if (accept) begin
      prev_sign <= sample_sign;
      if (update) begin
        gain     <= target;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  vca_serial_mul #(
    .nbit_data   (nbit_data),
    .nbit_sample (nbit_sample)
  ) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .start   (accept),
    .sample  (sample_in),
    .gain    (gain_nxt),
    .product (mul_product),
    .done    (mul_done)
  );

  // Output stage: result register and status strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      dout_valid <= mul_done;
      ovr        <= (state == MUL) && sample_valid;
      if (mul_done) dout <= mul_product;
    end
  end

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: crossings, hold timeout, vin gating, overrun and mid-multiply reset.
module tb_env_vca;

  logic              clk = 1'b0;
  logic              rstn;
  logic [5:0]        din;
  logic              vin;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  env_vca dut (
    .clk          (clk),
    .rstn         (rstn),
    .din          (din),
    .vin          (vin),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .busy         (busy),
    .ovr          (ovr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample to an idle DUT and check result and latency.
  task automatic send(input int s, input int exp, input string tag);
    int lat;
    sample_in    = 8'(s);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (dout_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 6);
    chk(tag, int'(dout), exp);
  endtask

  initial begin
    int n_ovr;
    int n_dv;
    int dv_val;

    rstn = 1'b0; din = '0; vin = 1'b0; sample_in = '0; sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_dv", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full-scale gain through alternating crossings
    vin = 1'b1; din = 6'd63;
    send(100, 0, "alt0");
    send(-100, -99, "alt1");
    send(100, 98, "alt2");
    send(-100, -99, "alt3");

    // Gain held between crossings
    send(100, 98, "pos_setup");
    din = 6'd32;
    send(10, 9, "held10");
    send(20, 19, "held20");
    send(30, 29, "held30");
    send(-5, -3, "cross_m5");

    // Hold timeout: gain 0, positive sign, hold counter cleared via a zero sample
    vin = 1'b0;
    send(0, 0, "zero_setup");
    vin = 1'b1; din = 6'd32;
    for (int i = 0; i < 64; i++)
      send(50, (i == 63) ? 25 : 0, $sformatf("hold%0d", i));

    // vin falls: gain stays until the next crossing
    din = 6'd63;
    send(-10, -10, "vin_setup_n");
    send(10, 9, "vin_setup_p");
    vin = 1'b0;
    send(40, 39, "vin_off40");
    send(-40, 0, "vin_off_m40");

    // Overrun: sample_valid held for three clocks
    vin = 1'b1; din = 6'd63;
    sample_in = 8'sd64; sample_valid = 1'b1;
    @(posedge clk); #1;
    chk("ovr_e0", int'(ovr), 0);
    chk("busy_e0", int'(busy), 1);
    @(posedge clk); #1;
    chk("ovr_e1", int'(ovr), 1);
    chk("busy_e1", int'(busy), 1);
    @(posedge clk); #1;
    chk("ovr_e2", int'(ovr), 1);
    chk("busy_e2", int'(busy), 1);
    sample_valid = 1'b0;
    n_ovr = 0; n_dv = 0; dv_val = -999;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ovr) n_ovr++;
      if (dout_valid) begin
        n_dv++;
        dv_val = int'(dout);
      end
    end
    chk("ovr_tail", n_ovr, 0);
    chk("ovr_dv_count", n_dv, 1);
    chk("ovr_dout", dv_val, 63);

    // Reset during the multiply
    sample_in = 8'sd100; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_pre", int'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("mid_dout", int'(dout), 0);
    chk("mid_dv", int'(dout_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ovr", int'(ovr), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_dv = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (dout_valid) n_dv++;
    end
    chk("mid_no_dv", n_dv, 0);
    send(100, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
